// File: rtl/wrapper_sha256_job_controller.sv
// SHA-256 job sequencer: accepts a size descriptor, drives the engine cfg
// beat, gates DMAC requests per phase, counts packets, watches for stalls.
//
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   job_size/valid/ready  job descriptor handshake (ready = idle)
//   abort                 level abort, honoured in DATA/DIGEST only
//   cfg_*                 engine configuration channel
//   in_beat_*, out_beat_* engine data handshake monitors
//   in/out_data_req(_i)   raw and phase-gated DMAC requests
//   busy, done_pulse      status and one-cycle completion strobe
//   err_len, err_timeout  sticky per-job error flags
//   blocks_remaining      input packets still expected
module wrapper_sha256_job_controller #(
  parameter int          CFGSIZEWIDTH   = 64,
  parameter int          CFGSCHEMEWIDTH = 2,
  parameter int unsigned SCHEME         = 0,
  parameter int          INPACKETWIDTH  = 512,
  parameter int          TIMEOUTWIDTH   = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [CFGSIZEWIDTH-1:0]   job_size,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic                      abort,
  output logic [CFGSIZEWIDTH-1:0]   cfg_size,
  output logic [CFGSCHEMEWIDTH-1:0] cfg_scheme,
  output logic                      cfg_last,
  output logic                      cfg_valid,
  input  logic                      cfg_ready,
  input  logic                      in_beat_valid,
  input  logic                      in_beat_ready,
  input  logic                      in_beat_last,
  input  logic                      out_beat_valid,
  input  logic                      out_beat_ready,
  input  logic                      in_data_req_i,
  output logic                      in_data_req,
  input  logic                      out_data_req_i,
  output logic                      out_data_req,
  output logic                      busy,
  output logic                      done_pulse,
  output logic                      err_len,
  output logic                      err_timeout,
  output logic [CFGSIZEWIDTH-1:0]   blocks_remaining
);

  localparam int EW       = CFGSIZEWIDTH + 1;
  localparam int PKTSHIFT = $clog2(INPACKETWIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    DATA   = 2'd2,
    DIGEST = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CFGSIZEWIDTH-1:0] size_q, size_d;
  logic [CFGSIZEWIDTH-1:0] rem_q, rem_d;
  logic                    err_len_q, err_len_d;
  logic                    err_to_q, err_to_d;
  logic                    done_q, done_d;

  logic                    cfg_hs;
  logic                    in_hs;
  logic                    out_hs;
  logic                    hs_any;
  logic                    wd_expired;
  logic                    timeout;

  // Ceiling division done one bit wider so the rounding add
  // cannot overflow at the maximum message length.
  logic [EW-1:0]           size_round;
  logic [EW-1:0]           blk_wide;
  logic [CFGSIZEWIDTH-1:0] blk_init;
  logic                    unused_blk;

  assign size_round = {1'b0, job_size} + EW'(INPACKETWIDTH - 1);
  assign blk_wide   = size_round >> PKTSHIFT;
  assign unused_blk = blk_wide[EW-1];
  assign blk_init   = (job_size == '0) ? CFGSIZEWIDTH'(1)
                                       : blk_wide[CFGSIZEWIDTH-1:0];

  assign cfg_hs = cfg_valid & cfg_ready;
  assign in_hs  = in_beat_valid & in_beat_ready;
  assign out_hs = out_beat_valid & out_beat_ready;
  assign hs_any = cfg_hs | in_hs | out_hs;

  // Any handshake this cycle counts as progress and beats the watchdog.
  assign timeout = wd_expired & ~hs_any;

  if (TIMEOUTWIDTH > 0) begin : g_wd
    logic [TIMEOUTWIDTH-1:0] wd_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        wd_cnt <= '0;
      end else if (state_q == IDLE || hs_any) begin
        wd_cnt <= '0;
      end else if (!(&wd_cnt)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end

    assign wd_expired = (state_q != IDLE) && (&wd_cnt);
  end else begin : g_no_wd
    assign wd_expired = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      size_q    <= '0;
      rem_q     <= '0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      rem_q     <= rem_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    rem_d     = rem_q;
    err_len_d = err_len_q;
    err_to_d  = err_to_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          size_d    = job_size;
          rem_d     = blk_init;
          err_len_d = 1'b0;
          err_to_d  = 1'b0;
          state_d   = CFG;
        end
      end
      CFG: begin
        // abort is not acted on here; it takes effect once in DATA
        if (cfg_ready) begin
          state_d = DATA;
        end else if (timeout) begin
          err_to_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      DATA: begin
        if (abort) begin
          rem_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (in_hs) begin
          if (rem_q <= CFGSIZEWIDTH'(1)) begin
            rem_d   = '0;
            state_d = DIGEST;
            if (!in_beat_last) err_len_d = 1'b1;
          end else if (in_beat_last) begin
            rem_d     = '0;
            err_len_d = 1'b1;
            state_d   = DIGEST;
          end else begin
            rem_d = rem_q - CFGSIZEWIDTH'(1);
          end
        end else if (timeout) begin
          err_to_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      DIGEST: begin
        if (abort) begin
          rem_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (out_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_to_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign job_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign cfg_valid        = (state_q == CFG);
  assign in_data_req      = in_data_req_i & (state_q == DATA);
  assign out_data_req     = out_data_req_i & (state_q == DIGEST);
  assign cfg_size         = size_q;
  assign cfg_scheme       = CFGSCHEMEWIDTH'(SCHEME);
  assign cfg_last         = 1'b1;
  assign done_pulse       = done_q;
  assign err_len          = err_len_q;
  assign err_timeout      = err_to_q;
  assign blocks_remaining = rem_q;

endmodule
